uart_frame_parser: RTL
======================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SOF, default 8'hA5: start-of-frame byte.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum payload bytes; legal range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100_000: maximum inter-byte gap in sys_clk cycles.
REQ-004 SHALL have port sys_clk, input, 1: the single clock.
REQ-005 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port uart_rx_done, input, 1: one-cycle pulse marking a valid received byte.
REQ-007 SHALL have port uart_rx_data, input, 8: received byte, sampled only when uart_rx_done=1.
REQ-008 SHALL have port pkt_valid, output, 1: payload byte available.
REQ-009 SHALL have port pkt_ready, input, 1: consumer accepts the byte.
REQ-010 SHALL have port pkt_data, output, 8: payload byte.
REQ-011 SHALL have port pkt_last, output, 1: marks the final payload byte of a frame.
REQ-012 SHALL have port frame_err, output, 1: one-cycle error pulse.
REQ-013 SHALL have port err_code, output, 2: error cause, valid with frame_err (0 length, 1 checksum, 2 overrun, 3 timeout).

Function
REQ-014 SHALL parse frames of the form SOF, LEN, LEN payload bytes, CSUM, where CSUM = (LEN + sum of payload) mod 256.
REQ-015 SHALL implement states IDLE, GET_LEN, GET_PAY, GET_CSUM and DRAIN.
REQ-016 IDLE SHALL move to GET_LEN on a byte equal to SOF and SHALL silently discard all other bytes.
REQ-017 GET_LEN SHALL move to IDLE with frame_err/err_code=0 when LEN=0 or LEN>MAX_LEN; otherwise it SHALL move to GET_PAY.
REQ-018 GET_PAY SHALL store bytes into buffer indices 0..LEN-1 and SHALL move to GET_CSUM after the LEN-th byte.
REQ-019 The running checksum SHALL be an 8-bit accumulator that wraps modulo 256.
REQ-020 On a CSUM mismatch, the parser SHALL move to IDLE with frame_err/err_code=1 and SHALL present no payload.
REQ-021 On a CSUM match, the parser SHALL enter DRAIN, with pkt_valid=1 in the cycle after the CSUM byte's uart_rx_done.
REQ-022 In DRAIN, a byte SHALL transfer when pkt_valid && pkt_ready, and the next index SHALL be presented in the following cycle.
REQ-023 pkt_data and pkt_last SHALL remain stable while pkt_valid && !pkt_ready.
REQ-024 pkt_last SHALL be 1 only on index LEN-1; a transfer with pkt_last=1 SHALL return the parser to IDLE, with pkt_valid=0 in the next cycle.
REQ-025 A uart_rx_done in DRAIN SHALL drop that byte and pulse frame_err/err_code=2, and draining SHALL continue unaffected.
REQ-026 SOF bytes arriving mid-frame SHALL be treated as ordinary data, with no resynchronisation.
REQ-027 When frame_err and a transfer fall in the same cycle, both SHALL take effect independently.

Reset
REQ-028 With sys_rst=1 at a sys_clk edge, the block SHALL go to IDLE with pkt_valid=0, pkt_data=0, pkt_last=0, frame_err=0, err_code=0, and the checksum, byte count and timeout counter cleared.
REQ-029 Reset mid-frame or mid-drain SHALL abandon the frame without signalling an error, and the buffer contents need not be cleared.

Configuration
REQ-030 With macro UART_PARSER_TIMEOUT_EN defined, a gap of TIMEOUT_CYC cycles without uart_rx_done in GET_LEN, GET_PAY or GET_CSUM SHALL return the parser to IDLE with frame_err/err_code=3.
REQ-031 The timeout counter SHALL clear on every uart_rx_done and in IDLE and DRAIN.
REQ-032 Without UART_PARSER_TIMEOUT_EN, the parser SHALL have no timeout counter logic, and err_code=3 SHALL never occur.

Structure
REQ-033 Package uart_pkg SHALL hold the parser state enum, the err_code constants and the default SOF value.
REQ-034 The payload storage SHALL be sub-module uart_frame_buf: MAX_LEN x 8, one write port, one read port, registered read.

Verification
REQ-035 Stimulus A5 03 11 22 33 69 with pkt_ready=1 -> outputs 11, 22, 33 on consecutive cycles, pkt_last on 33, and no frame_err.
REQ-036 Stimulus A5 02 10 20 00 -> frame_err with err_code=1, and pkt_valid stays 0.
REQ-037 Stimulus A5 00, then A5 with LEN=MAX_LEN+1 -> frame_err with err_code=0 for each, with the parser back in IDLE.
REQ-038 Good frame A5 01 FF 00 with pkt_ready held 0 for 5 cycles -> pkt_data=FF held stable, and a byte injected during the hold gives err_code=2.
REQ-039 Stimulus 00 7E, then a good frame -> leading bytes ignored and the frame delivered; sys_rst pulsed in GET_PAY -> IDLE, the next frame parses correctly.
REQ-040 With UART_PARSER_TIMEOUT_EN defined, stimulus A5 02 11 followed by a TIMEOUT_CYC idle gap -> frame_err with err_code=3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser: FSM state encoding,
// error cause codes and the default start-of-frame byte.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_LEN,
        ST_GET_PAY,
        ST_GET_CSUM,
        ST_DRAIN
    } parser_state_t;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 bits, one write port and one read
// port whose output register only updates when rd_en is asserted.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Holding rd_data when rd_en is low keeps the presented byte stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload/CSUM frames from a UART byte stream and drains the payload
// over a valid/ready interface. Define UART_PARSER_TIMEOUT_EN to enable the inter-byte timeout.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF         = DEFAULT_SOF,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 100_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rx_done,
    input  logic [7:0] uart_rx_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic [7:0] pkt_data,
    output logic       pkt_last,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    parser_state_t state, state_nxt;

    logic [7:0]    len;
    logic [7:0]    cnt;
    logic [7:0]    csum;
    logic [7:0]    rd_idx;
    logic          err_now;
    logic [1:0]    err_code_nxt;
    logic          xfer;
    logic          buf_wr_en;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;

    assign pkt_valid   = (state == ST_DRAIN);
    assign pkt_last    = pkt_valid && (rd_idx == len - 8'd1);
    assign xfer        = pkt_valid && pkt_ready;
    assign buf_wr_en   = (state == ST_GET_PAY) && uart_rx_done;
    assign buf_rd_addr = pkt_valid ? (rd_idx[AW-1:0] + AW'(1)) : '0;

`ifdef UART_PARSER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_wait;
    logic          tmo_hit;

    assign tmo_wait = (state == ST_GET_LEN) || (state == ST_GET_PAY) || (state == ST_GET_CSUM);
    assign tmo_hit  = tmo_wait && !uart_rx_done && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst || uart_rx_done || !tmo_wait) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        err_now      = 1'b0;
        err_code_nxt = ERR_LEN;
        buf_rd_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (uart_rx_done && uart_rx_data == SOF) begin
                    state_nxt = ST_GET_LEN;
                end
            end
            ST_GET_LEN: begin
                if (uart_rx_done) begin
                    if (uart_rx_data == 8'd0 || uart_rx_data > 8'(MAX_LEN)) begin
                        state_nxt    = ST_IDLE;
                        err_now      = 1'b1;
                        err_code_nxt = ERR_LEN;
                    end else begin
                        state_nxt = ST_GET_PAY;
                    end
                end
            end
            ST_GET_PAY: begin
                if (uart_rx_done && cnt == len - 8'd1) begin
                    state_nxt = ST_GET_CSUM;
                end
            end
            ST_GET_CSUM: begin
                // A match preloads buffer index 0 so the first byte is valid on DRAIN entry.
                if (uart_rx_done) begin
                    if (uart_rx_data == csum) begin
                        state_nxt = ST_DRAIN;
                        buf_rd_en = 1'b1;
                    end else begin
                        state_nxt    = ST_IDLE;
                        err_now      = 1'b1;
                        err_code_nxt = ERR_CSUM;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    buf_rd_en = !pkt_last;
                    if (pkt_last) begin
                        state_nxt = ST_IDLE;
                    end
                end
                if (uart_rx_done) begin
                    err_now      = 1'b1;
                    err_code_nxt = ERR_OVERRUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
`ifdef UART_PARSER_TIMEOUT_EN
        if (tmo_hit) begin
            state_nxt    = ST_IDLE;
            err_now      = 1'b1;
            err_code_nxt = ERR_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            len       <= 8'd0;
            cnt       <= 8'd0;
            csum      <= 8'd0;
            rd_idx    <= 8'd0;
            frame_err <= 1'b0;
            err_code  <= ERR_LEN;
        end else begin
            frame_err <= err_now;
            if (err_now) begin
                err_code <= err_code_nxt;
            end
            case (state)
                ST_IDLE: begin
                    cnt    <= 8'd0;
                    csum   <= 8'd0;
                    rd_idx <= 8'd0;
                end
                ST_GET_LEN: begin
                    if (uart_rx_done) begin
                        len  <= uart_rx_data;
                        csum <= uart_rx_data;
                    end
                end
                ST_GET_PAY: begin
                    if (uart_rx_done) begin
                        cnt  <= cnt + 8'd1;
                        csum <= csum + uart_rx_data;
                    end
                end
                ST_DRAIN: begin
                    if (xfer && !pkt_last) begin
                        rd_idx <= rd_idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (buf_wr_en),
        .wr_addr (cnt[AW-1:0]),
        .wr_data (uart_rx_data),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (pkt_data)
    );

endmodule
